uart_rx_word32: RTL and testbench

Serial receiver that assembles four UART byte frames into one 32-bit word, little-endian byte order (byte 0 = bits [7:0] arrives first). Each byte frame is 1 start bit, 8 data bits LSB first, 1 parity bit and 1 stop bit. The block sits on the uart_rx line of a 32-bit UART link and generates its own 16x oversample tick. It reports word-ready, parity, framing, overrun and inter-byte timeout conditions to the host logic.

---
 rtl/uart_rx_word32.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_word32.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word32.sv
// Receives four 8-bit data + parity + stop UART frames and assembles them, LSB byte first, into a 32-bit word.
// Latency: rx_data/rx_ready update one clk after the stop-bit mid-sample of the fourth byte.
// Backpressure: none; a word completed while rx_ready is still set raises overrun and is dropped.
module uart_rx_word32 #(
    parameter int CLK_FREQ     = 32000000,
    parameter int BAUD_RATE    = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    input  logic        parity_even_n,
    input  logic        rx_clear,
    output logic [31:0] rx_data,
    output logic        rx_ready,
    output logic        parity_error,
    output logic        framing_error,
    output logic        overrun
);

    localparam int DIV_RAW  = CLK_FREQ / (BAUD_RATE * 16);
    localparam int DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TO_LIMIT = TIMEOUT_BITS * 16;
    localparam int TW       = $clog2(TO_LIMIT + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t          state, state_nx;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic [DW-1:0]   div_cnt;
    logic            tick;
    logic [3:0]      samp_cnt;
    logic            samp7, samp8, maj;
    logic            at_mid, at_end;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic [31:0]     word_q;
    logic [1:0]      byte_idx;
    logic            word_bad;
    logic [TW-1:0]   to_cnt;
    logic            timeout_fire;
    logic            done_p;
    logic            clr_samp, shift_en, par_bad, stop_ok, stop_bad;

    assign rx_s   = sync_q[1];
    assign tick   = (div_cnt == DW'(DIV - 1));
    assign maj    = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);
    assign at_mid = tick && (samp_cnt == 4'd9);
    assign at_end = tick && (samp_cnt == 4'd15);
    assign timeout_fire = (state == IDLE) && (byte_idx != 2'd0) && tick
                          && (to_cnt == TW'(TO_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            div_cnt <= '0;
            state   <= IDLE;
        end else begin
            sync_q  <= {sync_q[0], uart_rx};
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            state   <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        clr_samp = 1'b0;
        shift_en = 1'b0;
        par_bad  = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nx = START;
                    clr_samp = 1'b1;
                end
            end
            START: begin
                if (at_mid && maj) state_nx = IDLE;
                else if (at_end)   state_nx = DATA;
            end
            DATA: begin
                shift_en = at_mid;
                if (at_end && bit_cnt == 3'd7) state_nx = PARITY;
            end
            PARITY: begin
                par_bad = at_mid && (maj != (^shreg ^ parity_even_n));
                if (at_end) state_nx = STOP;
            end
            STOP: begin
                // Leave at mid-stop so a back-to-back start edge is never missed.
                if (at_mid) begin
                    if (maj) begin
                        stop_ok  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_nx = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_cnt <= 4'd0;
            samp7    <= 1'b1;
            samp8    <= 1'b1;
            bit_cnt  <= 3'd0;
            shreg    <= 8'd0;
            word_q   <= 32'd0;
            byte_idx <= 2'd0;
            word_bad <= 1'b0;
            to_cnt   <= '0;
            done_p   <= 1'b0;
        end else begin
            done_p <= 1'b0;
            if (clr_samp)  samp_cnt <= 4'd0;
            else if (tick) samp_cnt <= samp_cnt + 4'd1;
            if (tick && samp_cnt == 4'd7) samp7 <= rx_s;
            if (tick && samp_cnt == 4'd8) samp8 <= rx_s;
            if (state == START)                bit_cnt <= 3'd0;
            else if (state == DATA && at_end)  bit_cnt <= bit_cnt + 3'd1;
            if (shift_en) shreg <= {maj, shreg[7:1]};
            if (par_bad) word_bad <= 1'b1;
            if (stop_ok) begin
                word_q[{byte_idx, 3'b000} +: 8] <= shreg;
                if (byte_idx == 2'd3) begin
                    byte_idx <= 2'd0;
                    word_bad <= 1'b0;
                    done_p   <= ~word_bad;
                end else begin
                    byte_idx <= byte_idx + 2'd1;
                end
            end else if (stop_bad || timeout_fire) begin
                byte_idx <= 2'd0;
                word_bad <= 1'b0;
            end
            // Idle gap is only policed once a word is partially assembled.
            if (state == IDLE && byte_idx != 2'd0) begin
                if (tick) to_cnt <= timeout_fire ? '0 : to_cnt + TW'(1);
            end else begin
                to_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data       <= 32'd0;
            rx_ready      <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            // A clear landing on the completion cycle makes room for the new word.
            if (done_p && (!rx_ready || rx_clear)) begin
                rx_data  <= word_q;
                rx_ready <= 1'b1;
            end else if (rx_clear) begin
                rx_ready <= 1'b0;
            end
            if (done_p && rx_ready && !rx_clear) overrun <= 1'b1;
            else if (rx_clear)                   overrun <= 1'b0;
            if (par_bad)       parity_error <= 1'b1;
            else if (rx_clear) parity_error <= 1'b0;
            if (stop_bad || timeout_fire) framing_error <= 1'b1;
            else if (rx_clear)            framing_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_word32.sv
// Frame-level bench for uart_rx_word32 at 16 clk per bit; expected outputs come from a byte/word model.
module tb_uart_rx_word32;

    localparam int TO_CLKS = 20 * 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        parity_even_n = 1'b0;
    logic        rx_clear = 1'b0;
    logic [31:0] rx_data;
    logic        rx_ready, parity_error, framing_error, overrun;

    int errors = 0;
    int checks = 0;
    int rise_j;
    logic [35:0] obs, exp_v;

    // Reference model state
    logic [31:0] m_data;
    bit          m_ready, m_perr, m_ferr, m_ovr, m_bad;
    int          m_idx;
    logic [7:0]  m_lane [4];

    always #5 clk = ~clk;

    uart_rx_word32 #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .TIMEOUT_BITS(20)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .parity_even_n(parity_even_n),
        .rx_clear(rx_clear), .rx_data(rx_data), .rx_ready(rx_ready),
        .parity_error(parity_error), .framing_error(framing_error), .overrun(overrun)
    );

    function automatic logic good_par(input logic [7:0] d);
        return ^d ^ parity_even_n;
    endfunction

    task automatic model_reset();
        m_data = 32'd0; m_ready = 0; m_perr = 0; m_ferr = 0; m_ovr = 0; m_bad = 0; m_idx = 0;
    endtask

    task automatic model_frame(input logic [7:0] d, input logic par, input logic stp, input bit clr);
        bit complete;
        complete = 0;
        if (par !== good_par(d)) begin m_perr = 1; m_bad = 1; end
        if (!stp) begin
            m_ferr = 1; m_idx = 0; m_bad = 0;
        end else begin
            m_lane[m_idx] = d;
            if (m_idx == 3) begin
                complete = !m_bad;
                m_idx = 0; m_bad = 0;
            end else begin
                m_idx++;
            end
        end
        if (clr) begin m_ready = 0; m_perr = 0; m_ferr = 0; m_ovr = 0; end
        if (complete) begin
            if (m_ready) m_ovr = 1;
            else begin
                m_data = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
                m_ready = 1;
            end
        end
    endtask

    // Called at a negedge; each bit lasts 16 clocks. clr pulses rx_clear on the completion cycle.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input bit clr);
        logic [9:0] bits;
        logic prev;
        bits = {par, d, 1'b0};
        rise_j = 0;
        for (int b = 0; b < 10; b++) begin
            uart_rx = bits[b];
            repeat (16) @(negedge clk);
        end
        uart_rx = stp;
        prev = rx_ready;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (rise_j == 0 && !prev && rx_ready) rise_j = j;
            prev = rx_ready;
            if (clr && j == 13) rx_clear = 1'b1;
            if (j == 14) rx_clear = 1'b0;
        end
        model_frame(d, par, stp, clr);
    endtask

    task automatic idle_line(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
        if (m_idx != 0 && n >= TO_CLKS) begin m_ferr = 1; m_idx = 0; m_bad = 0; end
    endtask

    task automatic send_word(input logic [31:0] w, input logic [3:0] flip, input bit clr_last, input int gap);
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            d = w[8*i +: 8];
            send_frame(d, good_par(d) ^ flip[i], 1'b1, clr_last && i == 3);
            if (i < 3 && gap > 0) idle_line(gap);
        end
    endtask

    task automatic clear_flags();
        rx_clear = 1'b1;
        @(negedge clk);
        rx_clear = 1'b0;
        m_ready = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        obs = {rx_data, rx_ready, parity_error, framing_error, overrun};
        checks++;
        if (obs !== 36'h0) begin errors++; $display("FAIL reset_state: got %h want %h", obs, 36'h0); end
        rst_n = 1'b1;
        model_reset();
        idle_line(10);
    endtask

    task automatic test_basic();
        parity_even_n = 1'b0;
        send_word(32'hDEADBEEF, 4'b0, 1'b0, 0);
        checks++;
        if (rise_j !== 14) begin errors++; $display("FAIL ready_latency: got negedge %0d want 14", rise_j); end
        obs = {rx_data, rx_ready, parity_error, framing_error, overrun};
        exp_v = {32'hDEADBEEF, 4'b1000};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL basic_word: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_odd_parity();
        clear_flags();
        parity_even_n = 1'b1;
        send_word(32'h00000001, 4'b0, 1'b0, 0);
        obs = {rx_data, rx_ready, parity_error, framing_error, overrun};
        exp_v = {32'h00000001, 4'b1000};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL odd_good: got %h want %h", obs, exp_v); end
        clear_flags();
        send_word(32'h00000001, 4'b0001, 1'b0, 0);
        obs = {rx_data, rx_ready, parity_error, framing_error, overrun};
        exp_v = {32'h00000001, 4'b0100};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL odd_bad: got %h want %h", obs, exp_v); end
        parity_even_n = 1'b0;
    endtask

    task automatic test_framing();
        clear_flags();
        send_frame(8'h5A, good_par(8'h5A), 1'b1, 1'b0);
        send_frame(8'hC3, good_par(8'hC3), 1'b1, 1'b0);
        send_frame(8'h77, good_par(8'h77), 1'b0, 1'b0);
        uart_rx = 1'b0;
        repeat (40) @(negedge clk);
        obs = {rx_data, rx_ready, parity_error, framing_error, overrun};
        exp_v = {m_data, m_ready, m_perr, m_ferr, m_ovr};
        checks++;
        if (obs !== exp_v || framing_error !== 1'b1) begin
            errors++; $display("FAIL stop_low: got %h want %h", obs, exp_v);
        end
        idle_line(20);
        send_word(32'h12345678, 4'b0, 1'b0, 0);
        obs = {rx_data, rx_ready, parity_error, framing_error, overrun};
        exp_v = {32'h12345678, 4'b1010};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL after_framing: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_glitch_timeout();
        logic [31:0] w;
        clear_flags();
        uart_rx = 1'b0;
        repeat (5) @(negedge clk);
        idle_line(40);
        obs = {rx_data, rx_ready, parity_error, framing_error, overrun};
        exp_v = {m_data, m_ready, m_perr, m_ferr, m_ovr};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL glitch: got %h want %h", obs, exp_v); end
        send_frame(8'hA1, good_par(8'hA1), 1'b1, 1'b0);
        send_frame(8'hB2, good_par(8'hB2), 1'b1, 1'b0);
        idle_line(400);
        obs = {rx_data, rx_ready, parity_error, framing_error, overrun};
        exp_v = {m_data, m_ready, m_perr, m_ferr, m_ovr};
        checks++;
        if (obs !== exp_v || m_ferr !== 1'b1) begin errors++; $display("FAIL timeout: got %h want %h", obs, exp_v); end
        clear_flags();
        w = $urandom;
        send_word(w, 4'b0, 1'b0, 0);
        obs = {rx_data, rx_ready, parity_error, framing_error, overrun};
        exp_v = {w, 4'b1000};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL after_timeout: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_overrun();
        clear_flags();
        send_word(32'h11111111, 4'b0, 1'b0, 0);
        send_word(32'h22222222, 4'b0, 1'b0, 0);
        obs = {rx_data, rx_ready, parity_error, framing_error, overrun};
        exp_v = {32'h11111111, 4'b1001};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL overrun: got %h want %h", obs, exp_v); end
        send_word(32'h33333333, 4'b0, 1'b1, 0);
        obs = {rx_data, rx_ready, parity_error, framing_error, overrun};
        exp_v = {32'h33333333, 4'b1000};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL clear_on_completion: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_reset_mid();
        send_frame(8'h0D, good_par(8'h0D), 1'b1, 1'b0);
        uart_rx = 1'b0;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        obs = {rx_data, rx_ready, parity_error, framing_error, overrun};
        checks++;
        if (obs !== 36'h0) begin errors++; $display("FAIL async_reset: got %h want %h", obs, 36'h0); end
        model_reset();
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        rst_n = 1'b1;
        idle_line(20);
        send_word(32'hCAFEF00D, 4'b0, 1'b0, 0);
        obs = {rx_data, rx_ready, parity_error, framing_error, overrun};
        exp_v = {32'hCAFEF00D, 4'b1000};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL after_reset: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [3:0]  flip;
        int          gap;
        for (int n = 0; n < 10; n++) begin
            parity_even_n = 1'($urandom_range(0, 1));
            w = $urandom;
            flip = ($urandom_range(0, 3) == 0) ? 4'(4'b0001 << $urandom_range(0, 3)) : 4'b0;
            gap = int'($urandom_range(0, 40));
            send_word(w, flip, 1'b0, gap);
            obs = {rx_data, rx_ready, parity_error, framing_error, overrun};
            exp_v = {m_data, m_ready, m_perr, m_ferr, m_ovr};
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL random_word%0d: got %h want %h", n, obs, exp_v);
            end
            if ($urandom_range(0, 1) == 1) clear_flags();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_odd_parity();
        test_framing();
        test_glitch_timeout();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
